// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file bus initiator.
package regfile_pkg;

   localparam int DEF_WIDTH = 20;
   localparam int DEF_DEPTH = 16;
   localparam int DEF_ADDR  = 4;
   localparam int DEF_LEN_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } rfi_state_t;

   // Addresses at or beyond the register count are refused at the register file.
   function automatic logic isBadAddr(input int unsigned addr, input int unsigned depth);
      return addr >= depth;
   endfunction

endpackage

// File: rtl/regfile_burst_ctr.sv
// Burst address/beat counter: loads a start address and length, then steps one beat per advance.
module regfile_burst_ctr
   import regfile_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int ADDR  = DEF_ADDR,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [ADDR-1:0]  i_addr,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_advance,
   output logic [ADDR-1:0]  o_addr,
   output logic             o_last
);

   localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

   logic [ADDR-1:0]  r_addr;
   logic [LEN_W-1:0] r_beats;

   // Address wraps at the register count, not at the address-field width.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr  <= '0;
         r_beats <= '0;
      end else if (i_load) begin
         r_addr  <= i_addr;
         r_beats <= i_len;
      end else if (i_advance) begin
         r_addr  <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
         r_beats <= r_beats - 1'b1;
      end
   end

   assign o_addr = r_addr;
   assign o_last = (r_beats == '0);

endmodule

// File: rtl/regfile_initiator.sv
// Bus initiator expanding burst commands into single-beat register-file writes and reads.
module regfile_initiator
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int ADDR  = DEF_ADDR,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [ADDR-1:0]  cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             cmd_err,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_last,
   output logic             busy,
   output logic             WrEn,
   output logic             RdEn,
   output logic [ADDR-1:0]  Address,
   output logic [WIDTH-1:0] WrData,
   input  logic [WIDTH-1:0] RdData
);

   rfi_state_t r_state;
   rfi_state_t w_nextState;

   logic r_bad;
   logic r_badQ;
   logic r_rspValid;
   logic r_rspLast;
   logic r_cmdErr;

   logic            w_accept;
   logic            w_cmdBad;
   logic            w_wrBeat;
   logic            w_issue;
   logic            w_advance;
   logic            w_last;
   logic [ADDR-1:0] w_addr;

   assign cmd_ready = (r_state == IDLE) & ~rst;
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_cmdBad  = isBadAddr(32'(cmd_addr), DEPTH);

   assign wr_ready  = (r_state == WRITE);
   assign w_wrBeat  = wr_ready & wr_valid;
   // A read beat may only be issued when the response slot is free or being emptied.
   assign w_issue   = (r_state == READ) & (~r_rspValid | rsp_ready);
   assign w_advance = w_wrBeat | w_issue;

   assign WrEn    = w_wrBeat & ~r_bad & ~rst;
   assign RdEn    = w_issue & ~r_bad & ~rst;
   assign Address = w_addr;
   assign WrData  = wr_data;

   assign rsp_valid = r_rspValid;
   assign rsp_last  = r_rspLast;
   assign rsp_data  = r_badQ ? '0 : RdData;
   assign cmd_err   = r_cmdErr;
   assign busy      = (r_state != IDLE);

   regfile_burst_ctr #(
      .DEPTH (DEPTH),
      .ADDR  (ADDR),
      .LEN_W (LEN_W)
   ) u_ctr (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_load    (w_accept),
      .i_addr    (cmd_addr),
      .i_len     (cmd_len),
      .i_advance (w_advance),
      .o_addr    (w_addr),
      .o_last    (w_last)
   );

   // State register plus the per-command bad-address flag and its error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_bad    <= 1'b0;
         r_cmdErr <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_cmdErr <= w_accept & w_cmdBad;
         if (w_accept) begin
            r_bad <= w_cmdBad;
         end
      end
   end

   // The final beat returns to IDLE on the same edge that consumes or issues it.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = cmd_write ? WRITE : READ;
            end
         end
         WRITE: begin
            if (w_wrBeat && w_last) begin
               w_nextState = IDLE;
            end
         end
         READ: begin
            if (w_issue && w_last) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // One-entry response slot; RdData stays put between strobes so only control is registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rspValid <= 1'b0;
         r_rspLast  <= 1'b0;
         r_badQ     <= 1'b0;
      end else if (w_issue) begin
         r_rspValid <= 1'b1;
         r_rspLast  <= w_last;
         r_badQ     <= r_bad;
      end else if (rsp_ready) begin
         r_rspValid <= 1'b0;
         r_rspLast  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_initiator.sv
// Bench for regfile_initiator: directed burst scenarios plus random bursts checked against a memory model.
module tb_regfile_initiator;

   localparam int WIDTH   = 20;
   localparam int ADDR    = 4;
   localparam int LEN_W   = 4;
   localparam int DEPTH   = 16;
   localparam int DEPTH_B = 12;
   localparam logic [WIDTH-1:0] B_RD_DATA = 20'h5A5A5;

   logic clk = 1'b0;
   logic rst;
   logic cmdValid, cmdWrite, wrValid, rspReady;
   logic [ADDR-1:0]  cmdAddr;
   logic [LEN_W-1:0] cmdLen;
   logic [WIDTH-1:0] wrData;

   logic cmdReady, cmdErr, wrReady, rspValid, rspLast, busy, wrEn, rdEn;
   logic [ADDR-1:0]  address;
   logic [WIDTH-1:0] rspData, regWrData, rdData;

   logic bCmdValid, bWrValid;
   logic bCmdReady, bCmdErr, bWrReady, bRspValid, bRspLast, bBusy, bWrEn, bRdEn;
   logic [ADDR-1:0]  bAddress;
   logic [WIDTH-1:0] bRspData, bWrData;

   regfile_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_write(cmdWrite),
      .cmd_addr(cmdAddr), .cmd_len(cmdLen), .cmd_err(cmdErr), .wr_valid(wrValid), .wr_ready(wrReady),
      .wr_data(wrData), .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_data(rspData), .rsp_last(rspLast),
      .busy(busy), .WrEn(wrEn), .RdEn(rdEn), .Address(address), .WrData(regWrData), .RdData(rdData)
   );

   regfile_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH_B), .ADDR(ADDR), .LEN_W(LEN_W)) dutB (
      .clk(clk), .rst(rst), .cmd_valid(bCmdValid), .cmd_ready(bCmdReady), .cmd_write(cmdWrite),
      .cmd_addr(cmdAddr), .cmd_len(cmdLen), .cmd_err(bCmdErr), .wr_valid(bWrValid), .wr_ready(bWrReady),
      .wr_data(wrData), .rsp_valid(bRspValid), .rsp_ready(rspReady), .rsp_data(bRspData), .rsp_last(bRspLast),
      .busy(bBusy), .WrEn(bWrEn), .RdEn(bRdEn), .Address(bAddress), .WrData(bWrData), .RdData(B_RD_DATA)
   );

   always #5 clk = ~clk;

   // Register file seen by the main instance: write on strobe, read data registered and held.
   logic [WIDTH-1:0] regMem [DEPTH];
   always @(posedge clk) begin
      if (wrEn) regMem[address] <= regWrData;
      if (rdEn) rdData <= regMem[address];
   end

   // Mid-cycle monitor collecting bus strobes and response handshakes.
   logic [ADDR-1:0]  wrAddrQ[$];
   logic [WIDTH-1:0] wrDataQ[$];
   logic [ADDR-1:0]  rdAddrQ[$];
   logic [WIDTH-1:0] rspQ[$];
   logic             lastQ[$];
   int overlapCnt = 0;
   int errCntA = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (wrEn) begin
            wrAddrQ.push_back(address);
            wrDataQ.push_back(regWrData);
         end
         if (rdEn) rdAddrQ.push_back(address);
         if (rspValid && rspReady) begin
            rspQ.push_back(rspData);
            lastQ.push_back(rspLast);
         end
         if ((wrEn && rdEn) || (bWrEn && bRdEn)) overlapCnt <= overlapCnt + 1;
         if (cmdErr) errCntA <= errCntA + 1;
      end
   end

   logic [WIDTH-1:0] refMem [DEPTH];
   logic [WIDTH-1:0] fixedQ[$];
   int total = 0;
   int bad = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sendCmd(input bit wr, input int addr, input int len);
      @(posedge clk); #1;
      cmdValid = 1'b1;
      cmdWrite = wr;
      cmdAddr  = ADDR'(addr);
      cmdLen   = LEN_W'(len);
      @(posedge clk); #1;
      cmdValid = 1'b0;
   endtask

   task automatic checkReads(input string tag, input int rBase, input int sBase, input int addr, input int len);
      int a;
      checkOutput({tag, ".rdCount"}, 32'(rdAddrQ.size() - rBase), 32'(len + 1));
      checkOutput({tag, ".rspCount"}, 32'(rspQ.size() - sBase), 32'(len + 1));
      for (int i = 0; i <= len; i++) begin
         a = (addr + i) % DEPTH;
         if (rBase + i < rdAddrQ.size())
            checkOutput({tag, ".rdAddr"}, 32'(rdAddrQ[rBase + i]), 32'(a));
         if (sBase + i < rspQ.size()) begin
            checkOutput({tag, ".rspData"}, 32'(rspQ[sBase + i]), 32'(refMem[a]));
            checkOutput({tag, ".rspLast"}, 32'(lastQ[sBase + i]), 32'(i == len));
         end
      end
   endtask

   task automatic applyStimulus(input string tag, input bit wr, input int addr, input int len, input int stallPct);
      int wBase, rBase, sBase, cyc, a;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] sent[$];
      wBase = wrAddrQ.size();
      rBase = rdAddrQ.size();
      sBase = rspQ.size();
      @(posedge clk); #1;
      cmdValid = 1'b1;
      cmdWrite = wr;
      cmdAddr  = ADDR'(addr);
      cmdLen   = LEN_W'(len);
      rspReady = 1'b0;
      wrValid  = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".cmdReady"}, 32'(cmdReady), 32'd1);
      @(posedge clk); #1;
      cmdValid = 1'b0;
      if (wr) begin
         for (int i = 0; i <= len; i++) begin
            while ($urandom_range(99) < stallPct) begin
               wrValid = 1'b0;
               @(posedge clk); #1;
            end
            d = WIDTH'($urandom);
            if (fixedQ.size() > 0) d = fixedQ.pop_front();
            wrValid = 1'b1;
            wrData  = d;
            sent.push_back(d);
            cyc = 0;
            @(negedge clk);
            while (!wrReady && cyc < 20) begin
               @(negedge clk);
               cyc++;
            end
            checkOutput({tag, ".wrReady"}, 32'(wrReady), 32'd1);
            @(posedge clk); #1;
         end
         wrValid = 1'b0;
         checkOutput({tag, ".idleAfter"}, 32'(busy), 32'd0);
         checkOutput({tag, ".wrCount"}, 32'(wrAddrQ.size() - wBase), 32'(len + 1));
         for (int i = 0; i <= len; i++) begin
            a = (addr + i) % DEPTH;
            refMem[a] = sent[i];
            if (wBase + i < wrAddrQ.size()) begin
               checkOutput({tag, ".wrAddr"}, 32'(wrAddrQ[wBase + i]), 32'(a));
               checkOutput({tag, ".wrData"}, 32'(wrDataQ[wBase + i]), 32'(sent[i]));
            end
         end
      end else begin
         cyc = 0;
         while (rspQ.size() - sBase < len + 1 && cyc < 400) begin
            rspReady = ($urandom_range(99) >= stallPct);
            @(posedge clk); #1;
            cyc++;
         end
         rspReady = 1'b0;
         checkOutput({tag, ".rdTimeout"}, 32'(cyc < 400), 32'd1);
         checkReads(tag, rBase, sBase, addr, len);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rBase, sBase, cyc, beats, wrEnSeen;
      rst = 1'b1;
      cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdLen = '0;
      wrValid = 1'b0; wrData = '0; rspReady = 1'b0;
      bCmdValid = 1'b0; bWrValid = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst.cmdReadyLow", 32'(cmdReady), 32'd0);
      checkOutput("rst.strobes", 32'({wrEn, rdEn, bWrEn, bRdEn}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst.cmdReady", 32'(cmdReady), 32'd1);
      checkOutput("rst.busy", 32'(busy), 32'd0);
      checkOutput("rst.rspValid", 32'(rspValid), 32'd0);
      checkOutput("rst.rspLast", 32'(rspLast), 32'd0);
      checkOutput("rst.cmdErr", 32'(cmdErr), 32'd0);
      checkOutput("rst.bIdle", 32'({bCmdReady, bBusy, bRspValid, bRspLast}), 32'b1000);

      applyStimulus("fill", 1'b1, 0, 15, 0);

      fixedQ.push_back(20'h11);
      fixedQ.push_back(20'h22);
      fixedQ.push_back(20'h33);
      applyStimulus("t1w", 1'b1, 3, 2, 20);
      applyStimulus("t1r", 1'b0, 3, 2, 0);

      applyStimulus("t2wrap", 1'b0, 14, 3, 30);

      // Response back-pressure: slot must hold and no new reads issue while stalled.
      rBase = rdAddrQ.size();
      sBase = rspQ.size();
      rspReady = 1'b0;
      sendCmd(1'b0, 5, 3);
      @(negedge clk);
      checkOutput("t3.firstIssue", 32'(rdEn), 32'd1);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("t3.holdRdEn", 32'(rdEn), 32'd0);
         checkOutput("t3.holdValid", 32'(rspValid), 32'd1);
         checkOutput("t3.holdData", 32'(rspData), 32'(refMem[5]));
         checkOutput("t3.holdLast", 32'(rspLast), 32'd0);
         @(posedge clk); #1;
      end
      rspReady = 1'b1;
      cyc = 0;
      while (rspQ.size() - sBase < 4 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      rspReady = 1'b0;
      checkReads("t3", rBase, sBase, 5, 3);

      // Full-rate read: strobes on cycles 0..7, responses one cycle behind.
      rBase = rdAddrQ.size();
      sBase = rspQ.size();
      rspReady = 1'b1;
      sendCmd(1'b0, 2, 7);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("t4.rdEn", 32'(rdEn), 32'(i <= 7));
         checkOutput("t4.rspValid", 32'(rspValid), 32'(i >= 1 && i <= 8));
         @(posedge clk); #1;
      end
      rspReady = 1'b0;
      checkReads("t4", rBase, sBase, 2, 7);

      // Reset in the middle of an 8-beat read after three responses.
      sBase = rspQ.size();
      rspReady = 1'b1;
      sendCmd(1'b0, 0, 7);
      cyc = 0;
      while (rspQ.size() - sBase < 3 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6.rdEnGated", 32'(rdEn), 32'd0);
      checkOutput("t6.cmdReadyInRst", 32'(cmdReady), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6.busy", 32'(busy), 32'd0);
      checkOutput("t6.rspValid", 32'(rspValid), 32'd0);
      checkOutput("t6.rdEn", 32'(rdEn), 32'd0);
      checkOutput("t6.cmdReady", 32'(cmdReady), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checkOutput("t6.quiet", 32'({rdEn, rspValid}), 32'd0);
      end
      @(posedge clk); #1;
      rspReady = 1'b0;
      checkOutput("t6.rspCount", 32'(rspQ.size() - sBase), 32'd3);

      // Out-of-range write on the 12-entry instance.
      @(posedge clk); #1;
      bCmdValid = 1'b1;
      cmdWrite  = 1'b1;
      cmdAddr   = 4'd13;
      cmdLen    = 4'd1;
      @(negedge clk);
      checkOutput("t5.cmdReady", 32'(bCmdReady), 32'd1);
      checkOutput("t5.errBefore", 32'(bCmdErr), 32'd0);
      @(posedge clk); #1;
      bCmdValid = 1'b0;
      bWrValid  = 1'b1;
      wrData    = 20'h12345;
      beats = 0;
      wrEnSeen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            checkOutput("t5.errPulse", 32'(bCmdErr), 32'd1);
            checkOutput("t5.address", 32'(bAddress), 32'd13);
            checkOutput("t5.wrData", 32'(bWrData), 32'h12345);
         end
         if (i == 1) checkOutput("t5.errClear", 32'(bCmdErr), 32'd0);
         if (bWrValid && bWrReady) beats++;
         if (bWrEn) wrEnSeen++;
         @(posedge clk); #1;
         if (beats == 2) bWrValid = 1'b0;
      end
      checkOutput("t5.beats", 32'(beats), 32'd2);
      checkOutput("t5.wrEnSeen", 32'(wrEnSeen), 32'd0);
      checkOutput("t5.idle", 32'(bBusy), 32'd0);

      // Out-of-range read: no strobes, zero data, last on the second beat.
      rspReady  = 1'b1;
      bCmdValid = 1'b1;
      cmdWrite  = 1'b0;
      @(posedge clk); #1;
      bCmdValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) checkOutput("t5r.errPulse", 32'(bCmdErr), 32'd1);
         checkOutput("t5r.rdEn", 32'(bRdEn), 32'd0);
         checkOutput("t5r.rspValid", 32'(bRspValid), 32'(i == 1 || i == 2));
         if (bRspValid) begin
            checkOutput("t5r.rspData", 32'(bRspData), 32'd0);
            checkOutput("t5r.rspLast", 32'(bRspLast), 32'(i == 2));
         end
         @(posedge clk); #1;
      end
      rspReady = 1'b0;

      for (int n = 0; n < 20; n++) begin
         applyStimulus("rnd", 1'($urandom_range(1)), int'($urandom_range(15)),
                       int'($urandom_range(15)), int'($urandom_range(60)));
      end

      @(posedge clk); #1;
      checkOutput("overlap", 32'(overlapCnt), 32'd0);
      checkOutput("cmdErrA", 32'(errCntA), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
